uart_tx_arbiter: RTL and testbench

Shares the single `rs232_uart` transmit path between two requesters: the PicoBlaze byte stream (port 03 writes) and a hardware status streamer that emits menu/state messages. Grants are message-granular: once a requester wins, it keeps the UART until it ends its message or goes idle past a timeout, so bytes from the two sources never interleave. The block sits between the requesters and the UART's `tx_data_in`/`write_tx_data`/`tx_buffer_full` pins.

---
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-granular arbiter sharing the UART transmit path between PicoBlaze and the status streamer
`timescale 1ns/1ps

module uart_tx_arbiter #(
   parameter logic [7:0]  EOM_CHAR = 8'h0A,
   parameter int unsigned TIMEOUT  = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] pb_tx_data,
   input  logic       pb_tx_valid,
   output logic       pb_tx_ready,
   input  logic [7:0] st_tx_data,
   input  logic       st_tx_valid,
   input  logic       st_tx_last,
   output logic       st_tx_ready,
   output logic [7:0] tx_data_out,
   output logic       write_tx_data,
   input  logic       tx_buffer_full,
   output logic [1:0] grant,
   output logic       timeout_flag
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      GRANT_PB = 2'b01,
      GRANT_ST = 2'b10
   } state_t;

   state_t        state;
   logic          last_owner_st;
   logic [CW-1:0] idle_cnt;
   logic          pb_xfer;
   logic          st_xfer;
   logic          granted_valid;
   logic          end_of_msg;

   assign grant = state;

   // The in-flight write blocks the next accept so the UART's late full flag is never overrun.
   assign pb_tx_ready = (state == GRANT_PB) & ~tx_buffer_full & ~write_tx_data;
   assign st_tx_ready = (state == GRANT_ST) & ~tx_buffer_full & ~write_tx_data;

   assign pb_xfer = pb_tx_valid & pb_tx_ready;
   assign st_xfer = st_tx_valid & st_tx_ready;

   assign granted_valid = ((state == GRANT_PB) & pb_tx_valid) |
                          ((state == GRANT_ST) & st_tx_valid);

   assign end_of_msg = (pb_xfer & (pb_tx_data == EOM_CHAR)) | (st_xfer & st_tx_last);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         last_owner_st <= 1'b1;
         idle_cnt      <= '0;
         tx_data_out   <= 8'h00;
         write_tx_data <= 1'b0;
         timeout_flag  <= 1'b0;
      end else begin
         write_tx_data <= pb_xfer | st_xfer;
         timeout_flag  <= 1'b0;

         if (pb_xfer) begin
            tx_data_out <= pb_tx_data;
         end else if (st_xfer) begin
            tx_data_out <= st_tx_data;
         end

         case (state)
            IDLE: begin
               idle_cnt <= '0;
               if (pb_tx_valid && (!st_tx_valid || last_owner_st)) begin
                  state <= GRANT_PB;
               end else if (st_tx_valid) begin
                  state <= GRANT_ST;
               end
            end

            GRANT_PB, GRANT_ST: begin
               if (pb_xfer || st_xfer) begin
                  idle_cnt <= '0;
                  if (end_of_msg) begin
                     state         <= IDLE;
                     last_owner_st <= st_xfer;
                  end
               // A blocked but valid requester holds the count, so backpressure cannot expire a grant.
               end else if (!granted_valid) begin
                  if (idle_cnt == TIMEOUT_CNT) begin
                     state         <= IDLE;
                     timeout_flag  <= 1'b1;
                     last_owner_st <= (state == GRANT_ST);
                     idle_cnt      <= '0;
                  end else begin
                     idle_cnt <= idle_cnt + CW'(1);
                  end
               end
            end

            default: begin
               state    <= IDLE;
               idle_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] pb_tx_data;
   logic       pb_tx_valid;
   logic       pb_tx_ready;
   logic [7:0] st_tx_data;
   logic       st_tx_valid;
   logic       st_tx_last;
   logic       st_tx_ready;
   logic [7:0] tx_data_out;
   logic       write_tx_data;
   logic       tx_buffer_full;
   logic [1:0] grant;
   logic       timeout_flag;

   uart_tx_arbiter #(.EOM_CHAR(8'h0A), .TIMEOUT(TO)) dut (
      .clk            (clk),
      .reset          (reset),
      .pb_tx_data     (pb_tx_data),
      .pb_tx_valid    (pb_tx_valid),
      .pb_tx_ready    (pb_tx_ready),
      .st_tx_data     (st_tx_data),
      .st_tx_valid    (st_tx_valid),
      .st_tx_last     (st_tx_last),
      .st_tx_ready    (st_tx_ready),
      .tx_data_out    (tx_data_out),
      .write_tx_data  (write_tx_data),
      .tx_buffer_full (tx_buffer_full),
      .grant          (grant),
      .timeout_flag   (timeout_flag)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   typedef struct {
      logic       pv;
      logic [7:0] pd;
      logic       sv;
      logic [7:0] sd;
      logic       sl;
      logic       fl;
      logic [1:0] g;
      logic       pr;
      logic       sr;
      logic       w;
      logic [7:0] d;
   } vec_t;

   function automatic vec_t mk(input logic pv, input logic [7:0] pd, input logic sv,
                               input logic [7:0] sd, input logic sl, input logic fl,
                               input logic [1:0] g, input logic pr, input logic sr,
                               input logic w, input logic [7:0] d);
      vec_t v;
      v.pv = pv; v.pd = pd; v.sv = sv; v.sd = sd; v.sl = sl; v.fl = fl;
      v.g = g; v.pr = pr; v.sr = sr; v.w = w; v.d = d;
      return v;
   endfunction

   // Reference model: per-source message streams; PB bytes are < 8'h80, ST bytes >= 8'h80.
   logic [7:0] pb_src[$];
   logic [7:0] st_src[$];
   logic       st_src_last[$];
   logic [7:0] pb_exp[$];
   logic [7:0] st_exp[$];
   logic       st_exp_last[$];

   bit         mon_en = 1'b0;
   int         cur_src = 0;
   int         tf_seen = 0;
   int         both_rdy = 0;
   logic       prev_w = 1'b0;
   logic       prev_full = 1'b0;
   logic [7:0] mb;
   logic [7:0] me;
   int         msrc;
   bit         mend;

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (write_tx_data) begin
               mb   = tx_data_out;
               msrc = mb[7] ? 2 : 1;
               chk("rand_wr_spacing", {prev_w, prev_full}, 0);
               chk("rand_no_interleave", (cur_src == 0 || msrc == cur_src), 1);
               me   = 'x;
               mend = 1'b0;
               if (msrc == 1) begin
                  if (pb_exp.size() > 0) me = pb_exp.pop_front();
                  mend = (mb == 8'h0A);
               end else begin
                  if (st_exp.size() > 0) begin
                     me   = st_exp.pop_front();
                     mend = st_exp_last.pop_front();
                  end
               end
               chk("rand_byte", mb, me);
               cur_src = mend ? 0 : msrc;
            end
            if (timeout_flag) tf_seen++;
            if (pb_tx_ready && st_tx_ready) both_rdy++;
         end
         prev_w    = write_tx_data;
         prev_full = tx_buffer_full;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   vec_t vt[19];
   int   bp_w, bp_tf, bp_r, tf_k, cyc, len, pb_off, st_off;
   logic pb_acc, st_acc;

   initial begin
      vt[0]  = mk(1, 8'h48, 1, 8'h81, 0, 0, 2'b00, 0, 0, 0, 8'h00);
      vt[1]  = mk(1, 8'h48, 1, 8'h81, 0, 0, 2'b01, 1, 0, 0, 8'h00);
      vt[2]  = mk(1, 8'h69, 1, 8'h81, 0, 0, 2'b01, 0, 0, 1, 8'h48);
      vt[3]  = mk(1, 8'h69, 1, 8'h81, 0, 0, 2'b01, 1, 0, 0, 8'h48);
      vt[4]  = mk(1, 8'h0A, 1, 8'h81, 0, 0, 2'b01, 0, 0, 1, 8'h69);
      vt[5]  = mk(1, 8'h0A, 1, 8'h81, 0, 0, 2'b01, 1, 0, 0, 8'h69);
      vt[6]  = mk(1, 8'h41, 1, 8'h81, 0, 0, 2'b00, 0, 0, 1, 8'h0A);
      vt[7]  = mk(1, 8'h41, 1, 8'h81, 0, 0, 2'b10, 0, 1, 0, 8'h0A);
      vt[8]  = mk(1, 8'h41, 1, 8'h82, 1, 0, 2'b10, 0, 0, 1, 8'h81);
      vt[9]  = mk(1, 8'h41, 1, 8'h82, 1, 0, 2'b10, 0, 1, 0, 8'h81);
      vt[10] = mk(1, 8'h41, 1, 8'h83, 1, 0, 2'b00, 0, 0, 1, 8'h82);
      vt[11] = mk(1, 8'h41, 1, 8'h83, 1, 0, 2'b01, 1, 0, 0, 8'h82);
      vt[12] = mk(1, 8'h0A, 1, 8'h83, 1, 0, 2'b01, 0, 0, 1, 8'h41);
      vt[13] = mk(1, 8'h0A, 1, 8'h83, 1, 1, 2'b01, 0, 0, 0, 8'h41);
      vt[14] = mk(1, 8'h0A, 1, 8'h83, 1, 0, 2'b01, 1, 0, 0, 8'h41);
      vt[15] = mk(0, 8'h00, 1, 8'h83, 1, 0, 2'b00, 0, 0, 1, 8'h0A);
      vt[16] = mk(0, 8'h00, 1, 8'h83, 1, 0, 2'b10, 0, 1, 0, 8'h0A);
      vt[17] = mk(0, 8'h00, 0, 8'h00, 0, 0, 2'b00, 0, 0, 1, 8'h83);
      vt[18] = mk(0, 8'h00, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0, 8'h83);

      reset = 1'b0;
      pb_tx_data = 8'h00; pb_tx_valid = 1'b0;
      st_tx_data = 8'h00; st_tx_valid = 1'b0; st_tx_last = 1'b0;
      tx_buffer_full = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_grant", grant, 0);
      chk("rst_pb_ready", pb_tx_ready, 0);
      chk("rst_st_ready", st_tx_ready, 0);
      chk("rst_data", tx_data_out, 0);
      chk("rst_write", write_tx_data, 0);
      chk("rst_timeout", timeout_flag, 0);
      reset = 1'b1;

      // Cycle-by-cycle table: PB message, round-robin tie-breaks, backpressure blip.
      for (int i = 0; i < 19; i++) begin
         @(posedge clk); #1;
         pb_tx_valid = vt[i].pv; pb_tx_data = vt[i].pd;
         st_tx_valid = vt[i].sv; st_tx_data = vt[i].sd; st_tx_last = vt[i].sl;
         tx_buffer_full = vt[i].fl;
         @(negedge clk);
         chk($sformatf("vec%0d_grant", i), grant, vt[i].g);
         chk($sformatf("vec%0d_pb_ready", i), pb_tx_ready, vt[i].pr);
         chk($sformatf("vec%0d_st_ready", i), st_tx_ready, vt[i].sr);
         chk($sformatf("vec%0d_write", i), write_tx_data, vt[i].w);
         chk($sformatf("vec%0d_data", i), tx_data_out, vt[i].d);
         chk($sformatf("vec%0d_timeout", i), timeout_flag, 0);
      end

      // Backpressure: 50 cycles full with ST pending must neither write nor time out.
      @(posedge clk); #1;
      st_tx_valid = 1'b1; st_tx_data = 8'h90; st_tx_last = 1'b1; tx_buffer_full = 1'b1;
      bp_w = 0; bp_tf = 0; bp_r = 0;
      repeat (50) begin
         @(negedge clk);
         bp_w += int'(write_tx_data);
         bp_tf += int'(timeout_flag);
         bp_r += int'(st_tx_ready);
      end
      chk("bp_grant_held", grant, 2'b10);
      chk("bp_no_write", bp_w, 0);
      chk("bp_no_timeout", bp_tf, 0);
      chk("bp_no_ready", bp_r, 0);
      @(posedge clk); #1;
      tx_buffer_full = 1'b0;
      @(negedge clk);
      chk("bp_release_ready", st_tx_ready, 1);
      @(posedge clk); #1;
      st_tx_valid = 1'b0; st_tx_last = 1'b0;
      @(negedge clk);
      chk("bp_release_write", write_tx_data, 1);
      chk("bp_release_data", tx_data_out, 8'h90);
      chk("bp_release_idle", grant, 0);

      // Timeout: PB sends one non-EOM byte then goes quiet while ST waits.
      @(posedge clk); #1;
      pb_tx_valid = 1'b1; pb_tx_data = 8'h55;
      st_tx_valid = 1'b1; st_tx_data = 8'hA1; st_tx_last = 1'b1;
      @(negedge clk);
      chk("to_idle_first", grant, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("to_pb_granted", grant, 2'b01);
      chk("to_pb_ready", pb_tx_ready, 1);
      @(posedge clk); #1;
      pb_tx_valid = 1'b0;
      @(negedge clk);
      chk("to_pb_write_data", tx_data_out, 8'h55);
      tf_k = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (timeout_flag) begin
            tf_k = k;
            break;
         end
      end
      chk("to_latency", tf_k, TO + 1);
      chk("to_grant_released", grant, 0);
      @(negedge clk);
      chk("to_flag_one_cycle", timeout_flag, 0);
      chk("to_st_granted", grant, 2'b10);
      chk("to_st_ready", st_tx_ready, 1);
      @(posedge clk); #1;
      st_tx_valid = 1'b0; st_tx_last = 1'b0;
      @(negedge clk);
      chk("to_st_write", write_tx_data, 1);
      chk("to_st_data", tx_data_out, 8'hA1);

      // Reset mid-operation, with PB as last owner so the post-reset tie proves the reset value.
      @(posedge clk); #1;
      pb_tx_valid = 1'b1; pb_tx_data = 8'h0A;
      @(posedge clk); #1;
      @(posedge clk); #1;
      pb_tx_data = 8'h66;
      @(posedge clk); #1;
      @(posedge clk); #1;
      pb_tx_data = 8'h0A;
      st_tx_valid = 1'b1; st_tx_data = 8'hB1; st_tx_last = 1'b1;
      @(negedge clk);
      chk("mr_write_before", write_tx_data, 1);
      chk("mr_data_before", tx_data_out, 8'h66);
      chk("mr_grant_before", grant, 2'b01);
      #1 reset = 1'b0;
      #1;
      chk("mr_write_cleared", write_tx_data, 0);
      chk("mr_grant_cleared", grant, 0);
      chk("mr_data_cleared", tx_data_out, 0);
      chk("mr_pb_ready", pb_tx_ready, 0);
      @(posedge clk); #1;
      chk("mr_held_idle", grant, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mr_tie_goes_pb", grant, 2'b01);
      @(posedge clk); #1;
      pb_tx_valid = 1'b0; st_tx_valid = 1'b0; st_tx_last = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Randomized message streams checked against the per-source model.
      for (int m = 0; m < 30; m++) begin
         len = $urandom_range(5, 1);
         for (int j = 0; j < len - 1; j++) pb_src.push_back(8'($urandom_range(8'h7F, 8'h20)));
         pb_src.push_back(8'h0A);
         len = $urandom_range(5, 1);
         for (int j = 0; j < len; j++) begin
            st_src.push_back(8'($urandom_range(8'hFF, 8'h80)));
            st_src_last.push_back(j == len - 1);
         end
      end
      pb_exp = pb_src;
      st_exp = st_src;
      st_exp_last = st_src_last;
      mon_en = 1'b1;
      cyc = 0; pb_off = 0; st_off = 0;
      pb_acc = 1'b0; st_acc = 1'b0;
      while ((pb_src.size() != 0 || st_src.size() != 0) && cyc < 20000) begin
         @(posedge clk); #1;
         if (pb_acc) void'(pb_src.pop_front());
         if (st_acc) begin
            void'(st_src.pop_front());
            void'(st_src_last.pop_front());
         end
         pb_tx_valid = (pb_src.size() != 0) && (pb_off >= 3 || $urandom_range(3, 0) != 0);
         pb_off = pb_tx_valid ? 0 : pb_off + 1;
         pb_tx_data = (pb_src.size() != 0) ? pb_src[0] : 8'h00;
         st_tx_valid = (st_src.size() != 0) && (st_off >= 3 || $urandom_range(3, 0) != 0);
         st_off = st_tx_valid ? 0 : st_off + 1;
         st_tx_data = (st_src.size() != 0) ? st_src[0] : 8'h00;
         st_tx_last = (st_src.size() != 0) ? st_src_last[0] : 1'b0;
         tx_buffer_full = ($urandom_range(2, 0) == 0);
         @(negedge clk);
         pb_acc = pb_tx_valid & pb_tx_ready;
         st_acc = st_tx_valid & st_tx_ready;
         cyc++;
      end
      @(posedge clk); #1;
      pb_tx_valid = 1'b0; st_tx_valid = 1'b0; st_tx_last = 1'b0; tx_buffer_full = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      mon_en = 1'b0;
      chk("rand_within_budget", (cyc < 20000), 1);
      chk("rand_pb_drained", pb_exp.size(), 0);
      chk("rand_st_drained", st_exp.size(), 0);
      chk("rand_msg_closed", cur_src, 0);
      chk("rand_no_timeout", tf_seen, 0);
      chk("rand_ready_exclusive", both_rdy, 0);
      chk("rand_final_idle", grant, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
